// File: rtl/control_unit.sv
// control_unit: password-gated commit of a configuration word, with lockout after repeated failures
module control_unit #(
  parameter int CFG_W = 35,
  parameter int LOCK_LIMIT = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             request,
  input  logic             confirm,
  input  logic [1:0]       password,
  input  logic [1:0]       syskey,
  input  logic [CFG_W-1:0] configin,
  output logic [CFG_W-1:0] configout,
  output logic             write_en,
  output logic [2:0]       dbg_state
);
  localparam int CW = $clog2(LOCK_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LOCK_LIMIT);
  typedef enum logic [2:0] {IDLE = 3'd0, CHECK = 3'd1, GRANTED = 3'd2, WRITE = 3'd3,
                            DENIED = 3'd4, LOCKED = 3'd5} state_t;
  state_t state, next;
  logic [CW-1:0] fail_cnt;
  logic commit;
  assign commit = state == GRANTED && request && confirm;
  assign write_en = state == WRITE;
  assign dbg_state = state;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = request ? CHECK : IDLE;
      CHECK:   next = !request ? IDLE : (password == syskey ? GRANTED : DENIED);
      GRANTED: next = !request ? IDLE : (confirm ? WRITE : GRANTED);
      WRITE:   next = IDLE;
      DENIED:  next = fail_cnt >= LIM ? LOCKED : IDLE;
      LOCKED:  next = LOCKED;
      default: next = IDLE;
    endcase
  end
  // fail_cnt is updated on the CHECK edge so DENIED already sees the new count
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state <= IDLE;
      fail_cnt <= '0;
      configout <= '0;
    end else begin
      state <= next;
      if (state == CHECK && request)
        fail_cnt <= password == syskey ? '0 : (fail_cnt >= LIM ? LIM : fail_cnt + 1'b1);
      if (commit)
        configout <= configin;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven check of control_unit plus hand-written reset sequences
module tb_control_unit;
  logic clk = 0, arst = 0, request = 0, confirm = 0;
  logic [1:0] password = 0, syskey = 0;
  logic [34:0] configin = 0, configout;
  logic write_en;
  logic [2:0] dbg_state;
  int tests = 0, fails = 0;

  control_unit dut (.clk(clk), .arst(arst), .request(request), .confirm(confirm),
                    .password(password), .syskey(syskey), .configin(configin),
                    .configout(configout), .write_en(write_en), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  typedef struct {
    logic req, conf;
    logic [1:0] pw;
    logic [34:0] cfg;
    logic [2:0] st;
    logic we;
    logic [34:0] cout;
  } vec_t;
  vec_t q[$];

  localparam logic [1:0] G = 2'b10, B = 2'b01;
  localparam logic [34:0] A = 35'h5_A5A5_A5A5, C = 35'h1_2345_6789, D = 35'h2_0000_0001;

  task automatic add(input logic req, conf, input logic [1:0] pw, input logic [34:0] cfg,
                     input logic [2:0] st, input logic we, input logic [34:0] cout);
    vec_t v;
    v.req = req; v.conf = conf; v.pw = pw; v.cfg = cfg; v.st = st; v.we = we; v.cout = cout;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    request = v.req; confirm = v.conf; password = v.pw; configin = v.cfg;
    @(posedge clk);
    #1;
    chk({tag, " state"}, 64'(dbg_state), 64'(v.st));
    chk({tag, " write_en"}, 64'(write_en), 64'(v.we));
    chk({tag, " configout"}, 64'(configout), 64'(v.cout));
  endtask

  initial begin
    syskey = G;
    #12;
    chk("reset state", 64'(dbg_state), 0);
    chk("reset write_en", 64'(write_en), 0);
    chk("reset configout", 64'(configout), 0);
    arst = 1;
    @(posedge clk); #1;
    chk("idle after reset", 64'(dbg_state), 0);
    // happy path
    add(1, 0, G, A, 1, 0, 0); add(1, 1, G, A, 2, 0, 0);
    add(1, 1, G, A, 3, 1, A); add(0, 0, G, A, 0, 0, A);
    // abort from GRANTED with confirm high; password changes outside CHECK ignored
    add(1, 0, G, D, 1, 0, A); add(1, 0, G, D, 2, 0, A);
    add(1, 0, B, D, 2, 0, A); add(0, 1, G, D, 0, 0, A);
    // request held through WRITE restarts CHECK; abort in CHECK
    add(1, 0, G, C, 1, 0, A); add(1, 0, G, C, 2, 0, A); add(1, 1, G, C, 3, 1, C);
    add(1, 0, G, C, 0, 0, C); add(1, 0, G, C, 1, 0, C); add(0, 0, G, C, 0, 0, C);
    // two failures, a correct check clears the count
    add(1, 0, B, C, 1, 0, C); add(1, 0, B, C, 4, 0, C); add(1, 0, B, C, 0, 0, C);
    add(1, 0, B, C, 1, 0, C); add(1, 0, B, C, 4, 0, C); add(0, 0, B, C, 0, 0, C);
    add(1, 0, G, C, 1, 0, C); add(1, 0, G, C, 2, 0, C); add(0, 0, G, C, 0, 0, C);
    // two more failures do not lock, an abort keeps the count, the third locks
    add(1, 0, B, C, 1, 0, C); add(1, 0, B, C, 4, 0, C); add(0, 0, B, C, 0, 0, C);
    add(1, 0, B, C, 1, 0, C); add(1, 0, B, C, 4, 0, C); add(0, 0, B, C, 0, 0, C);
    add(1, 0, B, C, 1, 0, C); add(0, 0, B, C, 0, 0, C);
    add(1, 0, B, C, 1, 0, C); add(1, 0, B, C, 4, 0, C);
    add(1, 1, G, D, 5, 0, C); add(1, 1, G, D, 5, 0, C); add(0, 0, G, D, 5, 0, C);
    for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("vec%0d", i));
    // async recovery from LOCKED
    arst = 0;
    #1;
    chk("lock reset state", 64'(dbg_state), 0);
    chk("lock reset configout", 64'(configout), 0);
    #1 arst = 1;
    q.delete();
    add(1, 0, G, A, 1, 0, 0); add(1, 0, G, A, 2, 0, 0); add(1, 1, G, A, 3, 1, A);
    add(0, 0, G, A, 0, 0, A); add(1, 0, G, A, 1, 0, A); add(1, 0, G, A, 2, 0, A);
    for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("post%0d", i));
    // reset asserted mid-GRANTED, between edges
    #2 arst = 0;
    #1;
    chk("mid reset state", 64'(dbg_state), 0);
    chk("mid reset configout", 64'(configout), 0);
    chk("mid reset write_en", 64'(write_en), 0);
    #1 arst = 1;
    request = 0; confirm = 0;
    @(posedge clk); #1;
    chk("after mid reset", 64'(dbg_state), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
